// File: rtl/seg8_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg8_arb_pkg
// Purpose  : Shared types, constants and round-robin helper for the display
//            arbiter and its leading-zero blanking generator.
// Revision : 1.0 - initial release
// ============================================================================
package seg8_arb_pkg;

    localparam int DIGITS  = 8;
    localparam int MAX_REQ = 8;
    localparam logic [DIGITS-1:0] BLANK_ALL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // First requester after ptr (wrapping modulo n); ptr itself is tried last.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i <= n) && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg8_lzb_gen.sv
`default_nettype none
// ============================================================================
// Module   : seg8_lzb_gen
// Purpose  : Leading-zero blanking mask for an 8-digit hex display.
// Revision : 1.0 - initial release
// ============================================================================
module seg8_lzb_gen
    import seg8_arb_pkg::*;
(
    input  logic [4*DIGITS-1:0] HEX,
    input  logic [DIGITS-1:0]   DP,
    input  logic                EN,
    output logic [DIGITS-1:0]   BLANK
);

    logic w_run;

    // Digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        BLANK = '0;
        w_run = EN;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_run    = w_run && (HEX[4*i +: 4] == 4'h0) && !DP[i];
            BLANK[i] = w_run;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg8_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg8_display_arbiter
// Purpose  : Round-robin owner arbitration of a shared 8-digit 7-segment
//            display with minimum dwell, blank gap on handover and scan CE.
// Revision : 1.0 - initial release
// ============================================================================
module seg8_display_arbiter
    import seg8_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DWELL_TICKS = 256
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [32*N_REQ-1:0] HEX_IN,
    input  logic [8*N_REQ-1:0]  DP_IN,
    input  logic [N_REQ-1:0]    LZB_EN,
    output logic [N_REQ-1:0]    GNT,
    output logic [2:0]          OWNER,
    output logic [31:0]         HEX_OUT,
    output logic [7:0]          DP_OUT,
    output logic [7:0]          BLANK_OUT,
    output logic                CE_SCAN
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_TICKS);

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [PW-1:0]    r_presc;
    logic [DW-1:0]    r_dwell;
    logic [2:0]       r_owner;
    logic [2:0]       r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [31:0]      r_hex;
    logic [7:0]       r_dp;
    logic [7:0]       r_blank;

    logic             w_ce;
    logic             w_grant;
    logic [2:0]       w_win;
    logic [MAX_REQ-1:0] w_req8;
    logic [N_REQ-1:0] w_owner_oh;
    logic             w_other;
    logic [31:0]      w_own_hex;
    logic [7:0]       w_own_dp;
    logic             w_own_lzb;
    logic             w_own_req;
    logic [7:0]       w_lzb;
    logic             w_hold_show;

    assign w_ce        = (r_presc == PRESC_MAX);
    assign w_owner_oh  = N_REQ'(1) << r_owner;
    assign w_other     = |(REQ & ~w_owner_oh);
    assign w_hold_show = (r_state == SHOW) && (w_next == SHOW);

    always_comb begin
        w_req8             = '0;
        w_req8[N_REQ-1:0]  = REQ;
    end

    assign w_win = rr_pick(w_req8, r_ptr, N_REQ);

    always_comb begin
        w_own_hex = '0;
        w_own_dp  = '0;
        w_own_lzb = 1'b0;
        w_own_req = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_owner == 3'(k)) begin
                w_own_hex = HEX_IN[32*k +: 32];
                w_own_dp  = DP_IN[8*k +: 8];
                w_own_lzb = LZB_EN[k];
                w_own_req = REQ[k];
            end
        end
    end

    seg8_lzb_gen u_lzb (
        .HEX   (w_own_hex),
        .DP    (w_own_dp),
        .EN    (w_own_lzb),
        .BLANK (w_lzb)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            IDLE: begin
                if (|REQ) begin
                    w_next  = SHOW;
                    w_grant = 1'b1;
                end
            end
            SHOW: begin
                if (!w_own_req || ((r_dwell == DWELL_MAX) && w_other))
                    w_next = GAP;
            end
            GAP: begin
                if (w_ce) begin
                    if (|REQ) begin
                        w_next  = SHOW;
                        w_grant = 1'b1;
                    end else begin
                        w_next  = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= '0;
            r_dwell <= '0;
            r_owner <= '0;
            r_ptr   <= 3'(N_REQ - 1);
            r_gnt   <= '0;
            r_hex   <= '0;
            r_dp    <= '0;
            r_blank <= BLANK_ALL;
        end else begin
            r_presc <= w_ce ? '0 : r_presc + 1'b1;

            if (w_grant) begin
                r_owner <= w_win;
                r_ptr   <= w_win;
                r_dwell <= '0;
                r_gnt   <= N_REQ'(1) << w_win;
            end else if (w_next != SHOW) begin
                r_gnt   <= '0;
            end else if (w_ce && (r_dwell != DWELL_MAX)) begin
                r_dwell <= r_dwell + 1'b1;
            end

            // Data only tracks the owner while it stays on screen; the grant
            // edge and the exit edge both leave the display blanked.
            if (w_hold_show) begin
                r_hex   <= w_own_hex;
                r_dp    <= w_own_dp;
                r_blank <= w_lzb;
            end else begin
                r_blank <= BLANK_ALL;
            end
        end
    end

    assign GNT       = r_gnt;
    assign OWNER     = r_owner;
    assign HEX_OUT   = r_hex;
    assign DP_OUT    = r_dp;
    assign BLANK_OUT = r_blank;
    assign CE_SCAN   = w_ce;

endmodule
`default_nettype wire

// File: tb/tb_seg8_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg8_display_arbiter
// Purpose  : Scoreboard bench for seg8_display_arbiter with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg8_display_arbiter;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int DT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [32*N-1:0]  hex_in = '0;
    logic [8*N-1:0]   dp_in = '0;
    logic [N-1:0]     lzb_en = '0;
    logic [N-1:0]     gnt;
    logic [2:0]       owner;
    logic [31:0]      hex_out;
    logic [7:0]       dp_out;
    logic [7:0]       blank_out;
    logic             ce_scan;

    seg8_display_arbiter #(.N_REQ(N), .SCAN_DIV(SD), .DWELL_TICKS(DT)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .REQ       (req),
        .HEX_IN    (hex_in),
        .DP_IN     (dp_in),
        .LZB_EN    (lzb_en),
        .GNT       (gnt),
        .OWNER     (owner),
        .HEX_OUT   (hex_out),
        .DP_OUT    (dp_out),
        .BLANK_OUT (blank_out),
        .CE_SCAN   (ce_scan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [2:0]   owner;
        logic [31:0]  hex;
        logic [7:0]   dp;
        logic [7:0]   blank;
        logic         ce;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Blank every digit above the most significant lit one, never digit 0.
    function automatic logic [7:0] lzb_ref(input logic [31:0] h, input logic [7:0] d, input logic en);
        int         msd;
        logic [7:0] m;
        msd = -1;
        for (int i = 7; i >= 0; i--)
            if (msd < 0 && (h[4*i +: 4] != 4'h0 || d[i])) msd = i;
        m = 8'hFF;
        m = m << (msd + 1);
        return en ? (m & 8'hFE) : 8'h00;
    endfunction

    function automatic int rr_ref(input logic [N-1:0] r, input int p);
        for (int off = 1; off <= N; off++)
            if (r[(p + off) % N]) return (p + off) % N;
        return p;
    endfunction

    // Reference model: 0=idle, 1=showing, 2=gap
    int         m_mode, m_owner, m_ptr, m_dwell, m_ticks;
    logic [31:0] m_hex;
    logic [7:0]  m_dp, m_blank;

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = N - 1; m_dwell = 0; m_ticks = 0;
        m_hex = '0; m_dp = '0; m_blank = 8'hFF;
    endtask

    task automatic model_grant();
        m_owner = rr_ref(req, m_ptr);
        m_ptr   = m_owner;
        m_dwell = 0;
        m_mode  = 1;
        m_blank = 8'hFF;
    endtask

    task automatic model_step();
        bit   ce_now;
        exp_t e;
        ce_now = (m_ticks % SD) == SD - 1;
        if (m_mode == 0) begin
            if (|req) model_grant();
        end else if (m_mode == 1) begin
            if (!req[m_owner] || (m_dwell == DT && (req & ~(N'(1) << m_owner)) != 0)) begin
                m_mode  = 2;
                m_blank = 8'hFF;
            end else begin
                m_hex   = hex_in[32*m_owner +: 32];
                m_dp    = dp_in[8*m_owner +: 8];
                m_blank = lzb_ref(m_hex, m_dp, lzb_en[m_owner]);
                if (ce_now && m_dwell < DT) m_dwell++;
            end
        end else begin
            m_blank = 8'hFF;
            if (ce_now) begin
                if (|req) model_grant();
                else m_mode = 0;
            end
        end
        m_ticks++;
        e.gnt   = (m_mode == 1) ? N'(1) << m_owner : '0;
        e.owner = 3'(m_owner);
        e.hex   = m_hex;
        e.dp    = m_dp;
        e.blank = m_blank;
        e.ce    = (m_ticks % SD) == SD - 1;
        sb.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_gnt",   32'(gnt),       32'(e.gnt));
                check("sb_owner", 32'(owner),     32'(e.owner));
                check("sb_hex",   hex_out,        e.hex);
                check("sb_dp",    32'(dp_out),    32'(e.dp));
                check("sb_blank", 32'(blank_out), 32'(e.blank));
                check("sb_ce",    32'(ce_scan),   32'(e.ce));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'h0);
        check({tag, "_blank"}, 32'(blank_out), 32'hFF);
        check({tag, "_ce"},    32'(ce_scan),   32'h0);
        check({tag, "_hex"},   hex_out,        32'h0);
        check({tag, "_owner"}, 32'(owner),     32'h0);
    endtask

    task automatic wait_gnt(input string name, input logic [N-1:0] want, input int limit);
        int n;
        n = 0;
        while (gnt !== want && n < limit) begin
            tick(1);
            n++;
        end
        check(name, 32'(gnt), 32'(want));
    endtask

    logic [N-1:0] seq[$];
    logic [N-1:0] prev;
    int           nz;
    logic [31:0]  v;
    int           k;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        // Reset held with all requests active
        rst_n = 1'b0;
        req   = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // Single request
        req = '0;
        hex_in[31:0] = 32'h9C32A792;
        dp_in[7:0]   = 8'h74;
        lzb_en       = '0;
        rst_n        = 1'b1;
        req          = 4'b0001;
        tick(1);
        check("single_gnt", 32'(gnt), 32'h1);
        tick(1);
        check("single_hex",   hex_out,        32'h9C32A792);
        check("single_dp",    32'(dp_out),    32'h74);
        check("single_blank", 32'(blank_out), 32'h00);

        // Leading-zero blanking
        lzb_en[0] = 1'b1; hex_in[31:0] = 32'h000000A5; dp_in[7:0] = 8'h00;
        tick(1);
        check("lzb_a5", 32'(blank_out), 32'hFC);
        hex_in[31:0] = 32'h0;
        tick(1);
        check("lzb_zero", 32'(blank_out), 32'hFE);
        hex_in[31:0] = 32'h000000A5; dp_in[7:0] = 8'h20;
        tick(1);
        check("lzb_dp", 32'(blank_out), 32'hC0);

        // Preemption by requester 2
        req = 4'b0101;
        wait_gnt("preempt_gnt", 4'b0100, 60);
        check("preempt_owner", 32'(owner), 32'h2);

        // Asynchronous reset in the middle of SHOW
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Early release while requester 3 waits
        req = 4'b1001;
        wait_gnt("early_first", 4'b0001, 10);
        k = 0;
        while (!ce_scan && k < 10) begin tick(1); k++; end
        tick(1);
        req = 4'b1000;
        wait_gnt("early_handover", 4'b1000, 20);
        req = 4'b0000;
        tick(12);
        check("idle_gnt",   32'(gnt),       32'h0);
        check("idle_blank", 32'(blank_out), 32'hFF);

        // Round-robin fairness with every requester active
        req  = 4'b1111;
        prev = '0;
        k    = 0;
        while (seq.size() < 5 && k < 300) begin
            tick(1);
            if (gnt != '0 && gnt != prev) seq.push_back(gnt);
            prev = gnt;
            k++;
        end
        check("rr_count", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5 && i < seq.size(); i++)
            check("rr_order", 32'(seq[i]), 32'(N'(1) << (i % N)));

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                k  = $urandom_range(0, N - 1);
                nz = $urandom_range(0, 8);
                v  = $urandom;
                v  = (nz == 8) ? 32'h0 : (v >> (4 * nz));
                hex_in[32*k +: 32] = v;
                dp_in[8*k +: 8]    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                lzb_en[k]          = 1'($urandom);
            end
            tick(1);
        end

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg8_display_arbiter.md
Name: seg8_display_arbiter

Overview:
Shares the 8-digit multiplexed 7-segment display driver between N_REQ requesters using a request/grant handshake.
- Round-robin arbitration with a minimum dwell time, so the display does not flicker between sources.
- Inserts a one-scan-period blank gap on every change of owner.
- Generates the scan clock-enable for the display driver.
- Computes leading-zero blanking per requester.
- Sits between the application sources and the 7-segment scan driver, feeding its HEX/DP/BLANK/CE inputs.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- SCAN_DIV, 1000: CLK cycles per CE_SCAN pulse (>=2).
- DWELL_TICKS, 256: minimum CE_SCAN pulses an owner keeps the display before it can be preempted (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous reset, active-low.
- REQ  in  N_REQ  per-requester display request, level.
- HEX_IN  in  32*N_REQ  requester k digits at [32k+31:32k]; nibble i is digit i; digit 7 is MSD.
- DP_IN  in  8*N_REQ  requester k decimal points; bit i is digit i.
- LZB_EN  in  N_REQ  enables leading-zero blanking for requester k.
- GNT  out  N_REQ  one-hot grant, registered.
- OWNER  out  3  index of the current or last owner.
- HEX_OUT  out  32  to display driver.
- DP_OUT  out  8  to display driver.
- BLANK_OUT  out  8  bit i=1 blanks digit i.
- CE_SCAN  out  1  one-CLK scan enable pulse.

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately):
  - state=IDLE, GNT=0, OWNER=0, HEX_OUT=0, DP_OUT=0, BLANK_OUT=8'hFF.
  - CE_SCAN=0, prescaler=0, dwell=0, RR pointer=N_REQ-1, so requester 0 wins first.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - CE_SCAN=1 for the cycle where the count is SCAN_DIV-1.
  - Free-running in all states.
- Round-robin pick: the first k with REQ[k]=1, searching ptr+1, ptr+2, ... modulo N_REQ. On each grant, ptr is set to the granted index.
- State IDLE: GNT=0, BLANK_OUT=8'hFF. If any REQ is high at a clock edge: GNT=onehot(winner), OWNER=winner, dwell=0, go to SHOW at that edge.
- State SHOW: every clock, HEX_OUT, DP_OUT and BLANK_OUT are registered from the owner's inputs. First valid data appears one clock after GNT rises.
- Dwell counter: increments on CE_SCAN and saturates at DWELL_TICKS.
- Release: REQ[OWNER]=0 -> next edge goes to GAP with GNT=0, regardless of dwell.
- Preempt: dwell==DWELL_TICKS and any REQ[j]=1 with j!=OWNER -> next edge goes to GAP with GNT=0.
- No other requester: the owner keeps the display indefinitely, and dwell stays saturated.
- Release and preempt in the same cycle behave identically: go to GAP.
- State GAP:
  - GNT=0, BLANK_OUT=8'hFF; HEX_OUT and DP_OUT hold.
  - On the next CE_SCAN: if any REQ, grant the RR winner and go to SHOW. The previous owner is eligible if it is still requesting and no one else is. Otherwise go to IDLE.
  - Result: the blank gap lasts 1..SCAN_DIV clocks.
- Leading-zero blanking (when LZB_EN[OWNER]=1):
  - BLANK_OUT[i]=1 for i=7..1 while every nibble j>=i is 0 and DP bit j is 0.
  - Blanking stops at the first non-zero nibble or set DP.
  - BLANK_OUT[0] is never set by LZB.
  - With LZB_EN=0, BLANK_OUT=8'h00 in SHOW.
- Grant stability:
  - GNT never has more than one bit set.
  - GNT is never asserted in GAP or IDLE.
  - Input data changes from the owner while in SHOW propagate with 1-cycle latency.

Decomposition:
- Package seg8_arb_pkg:
  - state enum {IDLE, SHOW, GAP}.
  - BLANK_ALL = 8'hFF.
  - Digit count constant = 8.
  - Round-robin pick function.
- Sub-module seg8_lzb_gen: combinational HEX[31:0] + DP[7:0] + EN -> BLANK[7:0], reused by the arbiter and other display sources.

Test Plan:
Common settings: N_REQ=4, SCAN_DIV=4, DWELL_TICKS=3.
- Reset: hold RST_N=0 with REQ=4'b1111 -> GNT=0, BLANK_OUT=8'hFF, CE_SCAN=0. After release, CE_SCAN pulses on every 4th CLK. Asserting RST_N=0 mid-SHOW clears all outputs without waiting for a clock edge.
- Single request: REQ=4'b0001, HEX_IN[31:0]=32'h9C32A792, DP_IN[7:0]=8'h74, LZB_EN=0 -> GNT=4'b0001 one edge later. The next edge gives HEX_OUT=32'h9C32A792, DP_OUT=8'h74, BLANK_OUT=8'h00.
- Leading-zero blanking: owner HEX=32'h000000A5, LZB_EN=1, DP=0 -> BLANK_OUT=8'hFC.
  - HEX=0 -> BLANK_OUT=8'hFE.
  - HEX=32'h000000A5 with DP=8'h20 -> BLANK_OUT=8'hC0.
- Preemption: owner 0 in SHOW with REQ=4'b0101 -> GNT stays 4'b0001 until the 3rd CE_SCAN. Then GNT=0 and BLANK_OUT=8'hFF until the next CE_SCAN, after which GNT=4'b0100.
- Early release: owner 0 drops REQ after 1 CE_SCAN while REQ[3]=1 -> GAP on the next edge, then GNT=4'b1000 at the next CE_SCAN. With REQ=0 everywhere, go to IDLE instead.
- Round-robin fairness: REQ=4'b1111 held continuously -> GNT sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts exactly 3 CE_SCAN pulses and is separated by a GAP.
